reg_file: RTL and testbench



---
 rtl/reg_file.sv | 73 +++++++
 tb/tb_reg_file.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// Architectural register file for the single-cycle MIPS datapath.
// Holds 2**ADDR_W registers with r0 hardwired to zero; two read ports, one write port, debug read, written-since-reset bitmap.
module reg_file #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [WIDTH-1:0]  rd_data_a,
  output logic [WIDTH-1:0]  rd_data_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              uninit_a,
  output logic              uninit_b,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int NREG = 2 ** ADDR_W;

  logic [WIDTH-1:0] mem [1:NREG-1];
  logic [NREG-1:1]  valid;
  logic             wr_commit;

  assign wr_commit = wr_en && (wr_addr != '0);

  // Storage starts at index 1, so address 0 never reaches a flop and always reads as zero.
  function automatic logic [WIDTH-1:0] read_reg(input logic [ADDR_W-1:0] a);
    read_reg = '0;
    for (int i = 1; i < NREG; i++) begin
      if (a == i[ADDR_W-1:0]) read_reg = mem[i];
    end
  endfunction

  function automatic logic is_uninit(input logic [ADDR_W-1:0] a);
    is_uninit = 1'b0;
    for (int i = 1; i < NREG; i++) begin
      if (a == i[ADDR_W-1:0]) is_uninit = ~valid[i];
    end
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < NREG; i++) mem[i] <= '0;
      valid    <= '0;
      wr_count <= '0;
    end else if (wr_commit) begin
      for (int i = 1; i < NREG; i++) begin
        if (wr_addr == i[ADDR_W-1:0]) begin
          mem[i]   <= wr_data;
          valid[i] <= 1'b1;
        end
      end
      if (wr_count != {CNT_W{1'b1}})
        wr_count <= wr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Reads see only committed storage: a bypass here would loop through the ALU.
  always_comb begin
    rd_data_a = read_reg(rd_addr_a);
    rd_data_b = read_reg(rd_addr_b);
    dbg_data  = read_reg(dbg_addr);
    uninit_a  = is_uninit(rd_addr_a);
    uninit_b  = is_uninit(rd_addr_b);
  end

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: a reference model predicts every read, predictions are queued and popped at sample time.
// A second instance with a 4-bit counter covers write-count saturation.
module tb_reg_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rd_addr_a = '0, rd_addr_b = '0, dbg_addr = '0, wr_addr = '0;
  logic [31:0] rd_data_a, rd_data_b, dbg_data, wr_data = '0;
  logic        wr_en = 1'b0;
  logic        uninit_a, uninit_b;
  logic [15:0] wr_count;

  logic [4:0]  ra4 = '0, rb4 = '0, dbg4 = '0, waddr4 = '0;
  logic [31:0] rda4, rdb4, dbgd4, wdata4 = '0;
  logic        wen4 = 1'b0;
  logic        ua4, ub4;
  logic [3:0]  cnt4;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] ea, eb, ed;
    logic        ua, ub;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] m_mem [32];
  logic        m_valid [32];
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  reg_file dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .uninit_a(uninit_a), .uninit_b(uninit_b),
    .wr_count(wr_count)
  );

  reg_file #(.WIDTH(32), .ADDR_W(5), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .rd_addr_a(ra4), .rd_addr_b(rb4),
    .rd_data_a(rda4), .rd_data_b(rdb4),
    .wr_en(wen4), .wr_addr(waddr4), .wr_data(wdata4),
    .dbg_addr(dbg4), .dbg_data(dbgd4),
    .uninit_a(ua4), .uninit_b(ub4),
    .wr_count(cnt4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      m_mem[i] = '0;
      m_valid[i] = 1'b0;
    end
    m_cnt = '0;
  endtask

  // Drive read addresses and queue what the model says they must return.
  task automatic applyStimulus(input string tag, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
    exp_t e;
    rd_addr_a = a;
    rd_addr_b = b;
    dbg_addr  = d;
    e.tag = tag;
    e.ea  = (a == 0) ? 32'h0 : m_mem[a];
    e.eb  = (b == 0) ? 32'h0 : m_mem[b];
    e.ed  = (d == 0) ? 32'h0 : m_mem[d];
    e.ua  = (a != 0) && !m_valid[a];
    e.ub  = (b != 0) && !m_valid[b];
    e.cnt = m_cnt;
    sbq.push_back(e);
  endtask

  task automatic sampleCheck();
    exp_t e;
    #1;
    e = sbq.pop_front();
    checkOutput({e.tag, ".rd_a"}, rd_data_a, e.ea);
    checkOutput({e.tag, ".rd_b"}, rd_data_b, e.eb);
    checkOutput({e.tag, ".dbg"}, dbg_data, e.ed);
    checkOutput({e.tag, ".uninit_a"}, {31'b0, uninit_a}, {31'b0, e.ua});
    checkOutput({e.tag, ".uninit_b"}, {31'b0, uninit_b}, {31'b0, e.ub});
    checkOutput({e.tag, ".wr_count"}, {16'b0, wr_count}, {16'b0, e.cnt});
  endtask

  // Drive one write, let the edge capture it, update the model, return at the next falling edge.
  task automatic doWrite(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk);
    if (rst_n && a != 0) begin
      m_mem[a] = d;
      m_valid[a] = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    repeat (2) @(negedge clk);
    applyStimulus("in_reset", 5'd3, 5'd0, 5'd31);
    sampleCheck();
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 32; i++) begin
      applyStimulus("reset_sweep", i[4:0], 5'(31 - i), i[4:0]);
      sampleCheck();
    end

    // Same-cycle read of the address being written returns the old value.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    applyStimulus("same_cycle", 5'd5, 5'd5, 5'd5);
    sampleCheck();
    doWrite(5'd5, 32'hDEADBEEF);
    wr_en = 1'b0;
    applyStimulus("after_edge", 5'd5, 5'd5, 5'd5);
    sampleCheck();

    doWrite(5'd0, 32'h12345678);
    wr_en = 1'b0;
    applyStimulus("r0_write", 5'd0, 5'd0, 5'd0);
    sampleCheck();

    for (int i = 1; i < 32; i++) doWrite(i[4:0], i * 32'h01010101);
    wr_en = 1'b0;
    for (int i = 0; i < 32; i++) begin
      applyStimulus("pattern", i[4:0], 5'(31 - i), 5'((i + 7) % 32));
      sampleCheck();
    end

    // Back-to-back writes to the same register: last one wins.
    doWrite(5'd12, 32'hAAAA0001);
    doWrite(5'd12, 32'hAAAA0002);
    wr_en = 1'b0;
    applyStimulus("b2b", 5'd12, 5'd11, 5'd12);
    sampleCheck();

    // Asynchronous reset mid-cycle with a write to r7 pending.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77777777;
    #2;
    rst_n = 1'b0;
    modelReset();
    applyStimulus("async_rst", 5'd5, 5'd7, 5'd20);
    sampleCheck();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wr_en = 1'b0;
    applyStimulus("post_rst_r7", 5'd7, 5'd7, 5'd7);
    sampleCheck();
    doWrite(5'd9, 32'hCAFEF00D);
    wr_en = 1'b0;
    applyStimulus("first_write", 5'd9, 5'd7, 5'd9);
    sampleCheck();

    // Saturating counter on the narrow-count instance.
    for (int i = 1; i <= 20; i++) begin
      wen4 = 1'b1; waddr4 = 5'd2; wdata4 = 32'h100 + i;
      @(posedge clk);
      @(negedge clk);
      if (i == 14) begin
        #1;
        checkOutput("sat.cnt14", {28'b0, cnt4}, 32'd14);
      end
    end
    wen4 = 1'b0;
    ra4 = 5'd2; rb4 = 5'd2; dbg4 = 5'd2;
    #1;
    checkOutput("sat.cnt", {28'b0, cnt4}, 32'd15);
    checkOutput("sat.r2", rda4, 32'h114);
    checkOutput("sat.dbg", dbgd4, 32'h114);

    if (sbq.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard: got %0d leftover expected 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
